cache_control_nway: RTL and testbench

- Parametrised successor to the 2-way cache controller: FSM for a WAYS-way set-associative, write-back, write-allocate cache.
- Sits between the CPU-side mem_* handshake and the physical-memory pmem_* handshake, and drives the way-indexed tag/valid/dirty/data/PLRU arrays in the cache datapath.
- New over the 2-way block:
  - Tree pseudo-LRU replacement.
  - Invalid-way-first victim choice.
  - Victim latched at miss time.
  - Per-byte write enables.
  - Replay of the lookup after a fill, so the miss completes without the CPU re-issuing.

---
 rtl/cache_nway_pkg.sv | 27 ++
 rtl/plru_tree.sv | 39 +++
 rtl/cache_control_nway.sv | 155 +++++++++++++++
 tb/tb_cache_control_nway.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way set-associative cache controller
// and its pseudo-LRU tree.
package cache_nway_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Tree nodes are heap-numbered from the root (node 0).
    // The right child (upper half of the ways) is 2i+1.
    // The left child (lower half of the ways) is 2i+2.
    function automatic int plru_right(input int node);
        return 2 * node + 1;
    endfunction

    function automatic int plru_left(input int node);
        return 2 * node + 2;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim walk and access update for one set's PLRU bits.
// A node bit of 0 points the victim at the left (lower-numbered) subtree.
module plru_tree
    import cache_nway_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int WAY_W = way_width(WAYS)
) (
    input  logic [WAYS-2:0]  plru_out,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-2:0]  plru_next
);

    always_comb begin
        int node;
        victim_way = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_way[WAY_W-1-l] = plru_out[node];
            node = plru_out[node] ? plru_right(node) : plru_left(node);
        end
    end

    // Each node on the accessed way's path is turned to point away from it.
    always_comb begin
        int  node;
        logic dir;
        plru_next = plru_out;
        node = 0;
        dir = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = access_way[WAY_W-1-l];
            plru_next[node] = ~dir;
            node = dir ? plru_right(node) : plru_left(node);
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// Controller FSM for a WAYS-way write-back, write-allocate cache.
// Misses are serviced by writeback/fill and then replayed through LOOKUP.
module cache_control_nway
    import cache_nway_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int BE_W = 32,
    localparam int WAY_W = way_width(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [BE_W-1:0]      mem_byte_enable,
    input  logic [WAYS-1:0]      tag_hit,
    input  logic [WAYS-1:0]      valid_out,
    input  logic [WAYS-1:0]      dirty_out,
    input  logic [WAYS-2:0]      plru_out,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic [WAY_W-1:0]     datamux_sel,
    output logic [WAYS*BE_W-1:0] write_en,
    output logic                 line_in_sel,
    output logic [WAYS-1:0]      load_tag,
    output logic [WAYS-1:0]      load_valid,
    output logic                 valid_in,
    output logic [WAYS-1:0]      load_dirty,
    output logic                 dirty_in,
    output logic                 load_plru,
    output logic [WAYS-2:0]      plru_in,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 addr_sel
);

    state_t            state_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic              is_write_reg;

    logic [WAYS-1:0]   hit;
    logic              any_hit;
    logic              any_invalid;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  invalid_way;
    logic [WAY_W-1:0]  plru_victim;
    logic [WAY_W-1:0]  victim_sel;
    logic [WAYS-2:0]   plru_next;

    assign hit         = tag_hit & valid_out;
    assign any_hit     = |hit;
    assign any_invalid = ~&valid_out;
    assign victim_sel  = any_invalid ? invalid_way : plru_victim;

    // Descending scans so the lowest matching index is the one kept.
    always_comb begin
        hit_way = '0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w])
                hit_way = WAY_W'(w);
            if (!valid_out[w])
                invalid_way = WAY_W'(w);
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_out   (plru_out),
        .access_way (hit_way),
        .victim_way (plru_victim),
        .plru_next  (plru_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            victim_reg   <= '0;
            is_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        state_reg    <= LOOKUP;
                        is_write_reg <= mem_write & ~mem_read;
                    end
                end
                LOOKUP: begin
                    if (any_hit) begin
                        state_reg <= IDLE;
                    end else begin
                        victim_reg <= victim_sel;
                        state_reg  <= (valid_out[victim_sel] && dirty_out[victim_sel])
                                      ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: if (pmem_resp) state_reg <= FILL;
                FILL:      if (pmem_resp) state_reg <= LOOKUP;
                default:   state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp    = 1'b0;
        datamux_sel = '0;
        write_en    = '0;
        line_in_sel = 1'b0;
        load_tag    = '0;
        load_valid  = '0;
        valid_in    = 1'b0;
        load_dirty  = '0;
        dirty_in    = 1'b0;
        load_plru   = 1'b0;
        plru_in     = '0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        addr_sel    = 1'b0;
        case (state_reg)
            LOOKUP: begin
                if (any_hit) begin
                    mem_resp    = 1'b1;
                    datamux_sel = hit_way;
                    load_plru   = 1'b1;
                    plru_in     = plru_next;
                    if (is_write_reg) begin
                        write_en[hit_way*BE_W +: BE_W] = mem_byte_enable;
                        line_in_sel         = 1'b1;
                        load_dirty[hit_way] = 1'b1;
                        dirty_in            = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                addr_sel    = 1'b1;
                datamux_sel = victim_reg;
                if (pmem_resp)
                    load_dirty[victim_reg] = 1'b1;
                else
                    pmem_write = 1'b1;
            end
            FILL: begin
                if (pmem_resp) begin
                    write_en[victim_reg*BE_W +: BE_W] = '1;
                    load_tag[victim_reg]   = 1'b1;
                    load_valid[victim_reg] = 1'b1;
                    valid_in               = 1'b1;
                    load_dirty[victim_reg] = 1'b1;
                end else begin
                    pmem_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4, BE_W=32): hits, misses,
// writeback, read/write precedence and asynchronous reset mid-transfer.
module tb_cache_control_nway;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [31:0]   mem_byte_enable;
    logic [3:0]    tag_hit, valid_out, dirty_out;
    logic [2:0]    plru_out;
    logic          pmem_resp;
    logic          mem_resp;
    logic [1:0]    datamux_sel;
    logic [127:0]  write_en;
    logic          line_in_sel;
    logic [3:0]    load_tag, load_valid, load_dirty;
    logic          valid_in, dirty_in, load_plru;
    logic [2:0]    plru_in;
    logic          pmem_read, pmem_write, addr_sel;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cache_control_nway #(.WAYS(4), .BE_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .tag_hit(tag_hit), .valid_out(valid_out), .dirty_out(dirty_out),
        .plru_out(plru_out), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .datamux_sel(datamux_sel), .write_en(write_en),
        .line_in_sel(line_in_sel), .load_tag(load_tag), .load_valid(load_valid),
        .valid_in(valid_in), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .load_plru(load_plru), .plru_in(plru_in), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .addr_sel(addr_sel)
    );

    wire [154:0] all_outs = {mem_resp, datamux_sel, write_en, line_in_sel, load_tag,
                             load_valid, valid_in, load_dirty, dirty_in, load_plru,
                             plru_in, pmem_read, pmem_write, addr_sel};

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
        tag_hit = '0; valid_out = '0; dirty_out = '0; plru_out = '0; pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        mem_read = 1'b1; tag_hit = 4'b0001; valid_out = 4'b0001;
        @(negedge clk); #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL reset_outs got=%h want=0", all_outs);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_read_hit();
        @(negedge clk);
        mem_read = 1'b1; tag_hit = 4'b0100; valid_out = 4'b0100; plru_out = 3'b000;
        #1; total++;
        if (mem_resp !== 1'b0) begin
            bad++; $display("FAIL rh_idle_resp got=%b want=0", mem_resp);
        end
        @(negedge clk); #1; total++;
        if ({mem_resp, datamux_sel, load_plru, plru_in, write_en, load_dirty, line_in_sel}
            !== {1'b1, 2'd2, 1'b1, 3'b010, 128'h0, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL rh_lookup got resp=%b sel=%0d lp=%b plru=%b we=%h ld=%b lis=%b want 1 2 1 010 0 0000 0",
                     mem_resp, datamux_sel, load_plru, plru_in, write_en, load_dirty, line_in_sel);
        end
        @(negedge clk);
        idle_inputs(); #1; total++;
        if (mem_resp !== 1'b0) begin
            bad++; $display("FAIL rh_single_pulse got=%b want=0", mem_resp);
        end
        $display("test_read_hit done");
    endtask

    task automatic test_write_hit();
        @(negedge clk);
        mem_write = 1'b1; mem_byte_enable = 32'h0000_00F0;
        tag_hit = 4'b0010; valid_out = 4'b1111; plru_out = 3'b000;
        @(negedge clk); #1; total++;
        if (write_en !== 128'h00000000_00000000_000000F0_00000000) begin
            bad++; $display("FAIL wh_write_en got=%h want=%h", write_en,
                            128'h00000000_00000000_000000F0_00000000);
        end
        total++;
        if ({mem_resp, datamux_sel, line_in_sel, load_dirty, dirty_in, load_plru, plru_in}
            !== {1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 3'b001}) begin
            bad++;
            $display("FAIL wh_ctrl got resp=%b sel=%0d lis=%b ld=%b di=%b lp=%b plru=%b want 1 1 1 0010 1 1 001",
                     mem_resp, datamux_sel, line_in_sel, load_dirty, dirty_in, load_plru, plru_in);
        end
        @(negedge clk);
        idle_inputs();
        $display("test_write_hit done");
    endtask

    task automatic test_read_miss_invalid();
        @(negedge clk);
        mem_read = 1'b1; tag_hit = 4'b0000; valid_out = 4'b0111; dirty_out = 4'b0111;
        plru_out = 3'b000;
        @(negedge clk); #1; total++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
            bad++; $display("FAIL rm_lookup got resp/rd/wr=%b want 000", {mem_resp, pmem_read, pmem_write});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1; total++;
            if ({pmem_read, pmem_write, addr_sel, load_tag} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
                bad++; $display("FAIL rm_fill_wait%0d got rd=%b wr=%b as=%b lt=%b want 1 0 0 0000",
                                i, pmem_read, pmem_write, addr_sel, load_tag);
            end
        end
        @(negedge clk);
        pmem_resp = 1'b1; #1; total++;
        if ({pmem_read, load_tag, load_valid, valid_in, load_dirty, dirty_in, line_in_sel, write_en}
            !== {1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 128'hFFFFFFFF_00000000_00000000_00000000}) begin
            bad++;
            $display("FAIL rm_fill_done got rd=%b lt=%b lv=%b vi=%b ld=%b di=%b lis=%b we=%h",
                     pmem_read, load_tag, load_valid, valid_in, load_dirty, dirty_in, line_in_sel, write_en);
        end
        tag_hit = 4'b1000; valid_out = 4'b1111; plru_out = 3'b111;
        @(negedge clk);
        pmem_resp = 1'b0; #1; total++;
        if ({mem_resp, datamux_sel, load_plru, plru_in, pmem_read} !== {1'b1, 2'd3, 1'b1, 3'b100, 1'b0}) begin
            bad++; $display("FAIL rm_replay got resp=%b sel=%0d lp=%b plru=%b rd=%b want 1 3 1 100 0",
                            mem_resp, datamux_sel, load_plru, plru_in, pmem_read);
        end
        @(negedge clk);
        idle_inputs();
        $display("test_read_miss_invalid done");
    endtask

    task automatic test_dirty_miss();
        @(negedge clk);
        mem_read = 1'b1; tag_hit = 4'b0000; valid_out = 4'b1111; dirty_out = 4'b1000;
        plru_out = 3'b011;
        @(negedge clk); #1; total++;
        if (mem_resp !== 1'b0) begin
            bad++; $display("FAIL dm_lookup got resp=%b want 0", mem_resp);
        end
        @(negedge clk); #1; total++;
        if ({pmem_write, pmem_read, addr_sel, datamux_sel} !== {1'b1, 1'b0, 1'b1, 2'd3}) begin
            bad++; $display("FAIL dm_wb_wait got wr=%b rd=%b as=%b sel=%0d want 1 0 1 3",
                            pmem_write, pmem_read, addr_sel, datamux_sel);
        end
        @(negedge clk);
        pmem_resp = 1'b1; #1; total++;
        if ({pmem_write, load_dirty, dirty_in, addr_sel} !== {1'b0, 4'b1000, 1'b0, 1'b1}) begin
            bad++; $display("FAIL dm_wb_done got wr=%b ld=%b di=%b as=%b want 0 1000 0 1",
                            pmem_write, load_dirty, dirty_in, addr_sel);
        end
        @(negedge clk);
        pmem_resp = 1'b0; #1; total++;
        if ({pmem_read, pmem_write, addr_sel} !== 3'b100) begin
            bad++; $display("FAIL dm_fill_wait got rd/wr/as=%b want 100", {pmem_read, pmem_write, addr_sel});
        end
        @(negedge clk);
        pmem_resp = 1'b1; #1; total++;
        if ({load_tag, load_valid} !== {4'b1000, 4'b1000}) begin
            bad++; $display("FAIL dm_fill_done got lt=%b lv=%b want 1000 1000", load_tag, load_valid);
        end
        tag_hit = 4'b1000; dirty_out = 4'b0000;
        @(negedge clk);
        pmem_resp = 1'b0; #1; total++;
        if ({mem_resp, datamux_sel} !== {1'b1, 2'd3}) begin
            bad++; $display("FAIL dm_replay got resp=%b sel=%0d want 1 3", mem_resp, datamux_sel);
        end
        @(negedge clk);
        idle_inputs();
        $display("test_dirty_miss done");
    endtask

    task automatic test_read_write_both();
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b1; mem_byte_enable = 32'hFFFF_FFFF;
        tag_hit = 4'b0000; valid_out = 4'b1110; dirty_out = 4'b1110; plru_out = 3'b000;
        @(negedge clk);
        @(negedge clk);
        pmem_resp = 1'b1; #1; total++;
        if ({line_in_sel, load_tag, write_en[31:0]} !== {1'b0, 4'b0001, 32'hFFFF_FFFF}) begin
            bad++; $display("FAIL rw_fill got lis=%b lt=%b we0=%h want 0 0001 ffffffff",
                            line_in_sel, load_tag, write_en[31:0]);
        end
        tag_hit = 4'b0001; valid_out = 4'b1111;
        @(negedge clk);
        pmem_resp = 1'b0; #1; total++;
        if ({mem_resp, datamux_sel, write_en, line_in_sel, load_dirty}
            !== {1'b1, 2'd0, 128'h0, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL rw_replay got resp=%b sel=%0d we=%h lis=%b ld=%b want 1 0 0 0 0000",
                            mem_resp, datamux_sel, write_en, line_in_sel, load_dirty);
        end
        @(negedge clk);
        idle_inputs();
        $display("test_read_write_both done");
    endtask

    task automatic test_reset_mid_writeback();
        @(negedge clk);
        mem_read = 1'b1; tag_hit = 4'b0000; valid_out = 4'b1111; dirty_out = 4'b1111;
        plru_out = 3'b000;
        @(negedge clk);
        @(negedge clk); #1; total++;
        if (pmem_write !== 1'b1) begin
            bad++; $display("FAIL rst_wb_active got wr=%b want 1", pmem_write);
        end
        #1 rst_n = 1'b0;
        #1; total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL rst_async_outs got=%h want=0", all_outs);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        mem_read = 1'b1; tag_hit = 4'b0001; valid_out = 4'b0001; plru_out = 3'b000;
        #1; total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL rst_idle_after got=%h want=0", all_outs);
        end
        @(negedge clk); #1; total++;
        if ({mem_resp, datamux_sel, plru_in} !== {1'b1, 2'd0, 3'b101}) begin
            bad++; $display("FAIL rst_next_hit got resp=%b sel=%0d plru=%b want 1 0 101",
                            mem_resp, datamux_sel, plru_in);
        end
        @(negedge clk);
        idle_inputs();
        $display("test_reset_mid_writeback done");
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_read_miss_invalid();
        test_dirty_miss();
        test_read_write_both();
        test_reset_mid_writeback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
